// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit for the EX stage; owns HI/LO.
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   start, mdOp     issue pulse and operation (0 mult, 1 multu, 2 div, 3 divu,
//                   4 mthi, 5 mtlo, 6 madd, 7 maddu)
//   dataA, dataB    rs / rt operands
//   readHi          mdOut select (1: HI, 0: LO)
//   busy            registered, high while a mult/div is in flight
//   hi, lo          architectural HI/LO
//   mdOut           combinational readHi ? hi : lo
// Optional feature: define MDU_MADD_EN to enable madd/maddu accumulation;
// otherwise ops 6/7 are accepted as no-ops.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdOp,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic        readHi,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdOut
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
  logic               sh_we_q, sh_we_d;

  // Operand arithmetic evaluated once at the start edge into the shadow regs.
  logic        [63:0] prod_s, prod_u;
  logic signed [31:0] div_a, div_b;
  logic signed [31:0] quot_s, rem_s;
  logic        [31:0] quot_u, rem_u;
  logic        [31:0] divisor_nz;
  logic               div_ovf;

  assign prod_s     = $signed({{32{dataA[31]}}, dataA}) * $signed({{32{dataB[31]}}, dataB});
  assign prod_u     = {32'd0, dataA} * {32'd0, dataB};
  // Substitute 1 for a zero divisor so the dividers never see /0; result is discarded.
  assign divisor_nz = (dataB == 32'd0) ? 32'd1 : dataB;
  assign div_ovf    = (dataA == 32'h8000_0000) && (dataB == 32'hFFFF_FFFF);
  assign div_a      = dataA;
  assign div_b      = (div_ovf) ? 32'sd1 : divisor_nz;
  assign quot_s     = div_a / div_b;
  assign rem_s      = div_a % div_b;
  assign quot_u     = dataA / divisor_nz;
  assign rem_u      = dataA % divisor_nz;

  // State and architectural registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
      sh_we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
      sh_we_q <= sh_we_d;
    end
  end

  // Next-state: countdown/commit, then issue of a new op (allowed on the commit edge).
  always_comb begin
    logic can_start;
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    sh_hi_d   = sh_hi_q;
    sh_lo_d   = sh_lo_q;
    sh_we_d   = sh_we_q;
    can_start = 1'b0;

    case (state_q)
      IDLE: can_start = 1'b1;
      RUN: begin
        if (cnt_q == CNT_W'(0)) begin
          state_d   = IDLE;
          can_start = 1'b1;
          sh_we_d   = 1'b0;
          if (sh_we_q) begin
            hi_d = sh_hi_q;
            lo_d = sh_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (start && can_start) begin
      case (mdOp)
        OP_MULT, OP_MULTU: begin
          {sh_hi_d, sh_lo_d} = (mdOp == OP_MULT) ? prod_s : prod_u;
          sh_we_d = 1'b1;
          state_d = RUN;
          cnt_d   = CNT_W'(MULT_CYCLES - 1);
        end
        OP_DIV: begin
          sh_lo_d = div_ovf ? 32'h8000_0000 : quot_s;
          sh_hi_d = div_ovf ? 32'd0 : rem_s;
          sh_we_d = (dataB != 32'd0);
          state_d = RUN;
          cnt_d   = CNT_W'(DIV_CYCLES - 1);
        end
        OP_DIVU: begin
          sh_lo_d = quot_u;
          sh_hi_d = rem_u;
          sh_we_d = (dataB != 32'd0);
          state_d = RUN;
          cnt_d   = CNT_W'(DIV_CYCLES - 1);
        end
        OP_MTHI: hi_d = dataA;
        OP_MTLO: lo_d = dataA;
`ifdef MDU_MADD_EN
        // Accumulate onto HI/LO as seen after any same-edge commit.
        OP_MADD, OP_MADDU: begin
          {sh_hi_d, sh_lo_d} = {hi_d, lo_d} + ((mdOp == OP_MADD) ? prod_s : prod_u);
          sh_we_d = 1'b1;
          state_d = RUN;
          cnt_d   = CNT_W'(MULT_CYCLES - 1);
        end
`endif
        default: ;
      endcase
    end
  end

  assign busy  = (state_q == RUN);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign mdOut = readHi ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops
// against a behavioural HI/LO model.
module tb_mult_div_unit;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdOp;
  logic [31:0] dataA, dataB;
  logic        readHi;
  logic        busy;
  logic [31:0] hi, lo, mdOut;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        p_valid;
  int          left;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .mdOp(mdOp),
    .dataA(dataA), .dataB(dataB), .readHi(readHi),
    .busy(busy), .hi(hi), .lo(lo), .mdOut(mdOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issue semantics from the op table, using plain integer arithmetic.
  task automatic model_issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          ps;
    longint unsigned pu;
    int              sa, sb;
    logic [63:0]     acc;
    sa = a; sb = b;
    ps = longint'(sa) * longint'(sb);
    pu = longint'({32'd0, a}) * longint'({32'd0, b});
    case (op)
      3'd0: begin {p_hi, p_lo} = ps; p_valid = 1; left = MC; end
      3'd1: begin {p_hi, p_lo} = pu; p_valid = 1; left = MC; end
      3'd2: begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          p_lo = 32'h8000_0000; p_hi = 0;
        end else if (b != 0) begin
          p_lo = sa / sb; p_hi = sa % sb;
        end
        p_valid = (b != 0); left = DC;
      end
      3'd3: begin
        if (b != 0) begin p_lo = a / b; p_hi = a % b; end
        p_valid = (b != 0); left = DC;
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: begin
`ifdef MDU_MADD_EN
        acc = {m_hi, m_lo} + ((op == 3'd6) ? 64'(ps) : 64'(pu));
        {p_hi, p_lo} = acc; p_valid = 1; left = MC;
`else
        acc = 0;
`endif
      end
    endcase
  endtask

  task automatic model_reset();
    m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; p_valid = 0; left = 0;
  endtask

  // One clock: drive on negedge, update model at posedge, compare #1 later.
  task automatic cyc(input logic st, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic rh);
    @(negedge clk);
    start = st; mdOp = op; dataA = a; dataB = b; readHi = rh;
    @(posedge clk);
    if (left > 0) begin
      left--;
      if (left == 0 && p_valid) begin m_hi = p_hi; m_lo = p_lo; end
    end
    if (left == 0 && st) model_issue(op, a, b);
    #1;
    chk("busy", 32'(busy), 32'(left != 0));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("mdOut", mdOut, rh ? m_hi : m_lo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 0;
    reset = 1;
    #1;
    model_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    reset = 1; start = 0; mdOp = 0; dataA = 0; dataB = 0; readHi = 0;
    model_reset();
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 0;

    // mult -2*3
    cyc(1, 3'd0, 32'hFFFF_FFFE, 32'd3, 0);
    idle(MC);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // multu max*max
    cyc(1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    idle(MC);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    // div -7/2, with a mult attempted mid-flight (ignored)
    cyc(1, 3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    cyc(0, 3'd0, 0, 0, 0);
    cyc(1, 3'd0, 32'd100, 32'd100, 0);
    idle(DC - 2);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // divu by zero keeps HI/LO
    cyc(1, 3'd3, 32'd7, 32'd0, 0);
    idle(DC);
    chk("divu0_lo", lo, 32'hFFFF_FFFD);

    // signed overflow
    cyc(1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    idle(DC);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);

    // mthi, then read via mdOut
    cyc(1, 3'd4, 32'h1234, 0, 0);
    cyc(0, 3'd0, 0, 0, 1);
    chk("mfhi", mdOut, 32'h1234);

    // back-to-back: new start on the commit edge
    cyc(1, 3'd1, 32'd6, 32'd7, 0);
    idle(MC - 1);
    cyc(1, 3'd1, 32'd2, 32'd3, 0);
    chk("b2b_lo", lo, 32'd42);
    idle(MC);
    chk("b2b_lo2", lo, 32'd6);

    // reset mid-mult
    cyc(1, 3'd0, 32'd9, 32'd9, 0);
    idle(2);
    do_reset();
    idle(MC + 1);
    chk("abort_lo", lo, 32'd0);

`ifdef MDU_MADD_EN
    cyc(1, 3'd5, 32'd5, 0, 0);
    cyc(1, 3'd6, 32'd2, 32'd3, 0);
    idle(MC);
    chk("madd_lo", lo, 32'd11);
    chk("madd_hi", hi, 32'd0);
`else
    cyc(1, 3'd6, 32'd2, 32'd3, 0);
    chk("madd_nop_busy", 32'(busy), 32'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, b;
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 9))
        0: b = 0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(0, 15);
        default: ;
      endcase
      if ($urandom_range(0, 299) == 0) do_reset();
      else cyc(1'($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)), a, b,
               1'($urandom_range(0, 1)));
    end
    idle(DC + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
